ccd_line_driver: RTL

CCD_LINE_DRIVER -- requirements
Module: ccd_line_driver

---
 rtl/ccd_line_driver.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ccd_line_driver.sv
`timescale 1ns/1ps
// ccd_line_driver: CCD line timing generator (SH, F1/F2, RS, CP, pixel valid) paced by a pixel clock-enable.
// Define CCD_SHUTTER_EN to add the shut_pos input and an electronic-shutter second SH pulse.
module ccd_line_driver #(
    parameter int LINE_WIDTH = 2088,
    parameter int LOAD_CLKS  = 13,
    parameter int SH_START   = 2,
    parameter int SH_END     = 9,
    parameter int CNT_W      = 23
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic [7:0]       f1_freq,
    input  logic [CNT_W-1:0] f_cnt,
    input  logic             mode,
    input  logic             start,
`ifdef CCD_SHUTTER_EN
    input  logic [CNT_W-1:0] shut_pos,
`endif
    output logic             sh,
    output logic             f1,
    output logic             f2,
    output logic             rs,
    output logic             cp,
    output logic             pclk,
    output logic             rs_plus,
    output logic             os_tvalid,
    output logic             os_first,
    output logic             busy,
    output logic             trig_ovr,
    output logic [15:0]      line_cnt
);

    typedef enum logic [1:0] {IDLE, LOAD, TRAN, WAIT} state_t;

    localparam logic [CNT_W-1:0] LOAD_LAST  = CNT_W'(LOAD_CLKS - 1);
    localparam logic [CNT_W-1:0] TRAN_LAST  = CNT_W'(LINE_WIDTH - 1);
    localparam logic [CNT_W-1:0] SH_FIRST   = CNT_W'(SH_START);
    localparam logic [CNT_W-1:0] SH_LAST    = CNT_W'(SH_END);
    localparam logic [CNT_W-1:0] MIN_PERIOD = CNT_W'(LINE_WIDTH + LOAD_CLKS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pix, pix_nxt;
    logic [CNT_W-1:0] f_lat, wait_last;
    logic             has_wait;
    logic             armed, pending, consume, tran_exit;
    logic [7:0]       div_cnt, div_nxt, f1_even, n_live, n_lat, n_eff;
    logic             tick, cp_phase, f1_hold, gate, shut_on;

    // Divisor follows the input while idle and is frozen for the duration of a line.
    assign f1_even = f1_freq & 8'hFE;
    assign n_live  = (f1_even < 8'd4) ? 8'd4 : f1_even;
    assign n_eff   = (state == IDLE) ? n_live : n_lat;
    assign tick    = (div_cnt >= n_eff - 8'd1);
    assign div_nxt = tick ? 8'd0 : div_cnt + 8'd1;

    // NOTE: state uses non-blocking assignments with an asynchronous reset so every
    // register updates from pre-edge values and reset never waits for a clock edge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            div_cnt  <= '0;
            pclk     <= 1'b0;
            rs_plus  <= 1'b0;
            cp_phase <= 1'b0;
        end else begin
            div_cnt  <= div_nxt;
            pclk     <= (div_nxt < (n_eff >> 1));
            rs_plus  <= (div_nxt < 8'd2);
            cp_phase <= (div_nxt == 8'd2) || (div_nxt == 8'd3);
        end
    end

    assign has_wait  = (f_lat > MIN_PERIOD);
    assign wait_last = f_lat - MIN_PERIOD - CNT_ONE;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pix_nxt   = pix;
        consume   = 1'b0;
        tran_exit = 1'b0;
        if (tick) begin
            pix_nxt = pix + CNT_ONE;
            unique case (state)
                IDLE: begin
                    pix_nxt = '0;
                    if (armed && (!mode || pending)) begin
                        state_nxt = LOAD;
                        consume   = 1'b1;
                    end
                end
                LOAD: if (pix == LOAD_LAST) begin
                    state_nxt = TRAN;
                    pix_nxt   = '0;
                end
                TRAN: if (pix == TRAN_LAST) begin
                    state_nxt = has_wait ? WAIT : IDLE;
                    pix_nxt   = '0;
                    tran_exit = 1'b1;
                end
                WAIT: if (pix == wait_last) begin
                    state_nxt = IDLE;
                    pix_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            pix      <= '0;
            armed    <= 1'b0;
            pending  <= 1'b0;
            trig_ovr <= 1'b0;
            n_lat    <= 8'd4;
            f_lat    <= '0;
            line_cnt <= '0;
        end else begin
            state    <= state_nxt;
            pix      <= pix_nxt;
            trig_ovr <= start && pending && !consume;
            if (tick && state == IDLE) armed <= 1'b1;
            // A trigger arriving on the consuming cycle is kept for the next line.
            if (consume) pending <= start;
            else if (start) pending <= 1'b1;
            if (consume) begin
                n_lat <= n_live;
                f_lat <= f_cnt;
            end
            if (tran_exit) line_cnt <= line_cnt + 16'd1;
        end
    end

`ifdef CCD_SHUTTER_EN
    localparam int             CW1      = CNT_W + 1;
    localparam logic [CNT_W:0] SHUT_LEN = CW1'(SH_END - SH_START + 1);
    localparam logic [CNT_W:0] LOAD_LEN = CW1'(LOAD_CLKS);

    logic [CNT_W-1:0] line_pos, shut_lat;
    logic [CNT_W:0]   period_x, shut_end_x;
    logic             shut_ok, shut_ok_nxt;

    assign period_x    = (f_cnt > MIN_PERIOD) ? {1'b0, f_cnt} : {1'b0, MIN_PERIOD};
    assign shut_end_x  = {1'b0, shut_pos} + SHUT_LEN;
    assign shut_ok_nxt = ({1'b0, shut_pos} >= LOAD_LEN) && (shut_end_x <= period_x - CW1'(1));

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            line_pos <= '0;
            shut_lat <= '0;
            shut_ok  <= 1'b0;
        end else begin
            if (consume) begin
                line_pos <= '0;
                shut_lat <= shut_pos;
                shut_ok  <= shut_ok_nxt;
            end else if (tick && state != IDLE) begin
                line_pos <= line_pos + CNT_ONE;
            end
        end
    end

    assign shut_on = shut_ok && busy && (line_pos >= shut_lat) &&
                     ({1'b0, line_pos} < {1'b0, shut_lat} + SHUT_LEN);
`else
    assign shut_on = 1'b0;
`endif

    assign busy      = (state != IDLE);
    assign f1_hold   = (state == LOAD);
    assign gate      = !f1_hold;
    assign sh        = (f1_hold && pix >= SH_FIRST && pix <= SH_LAST) || shut_on;
    assign os_tvalid = (state == TRAN);
    assign os_first  = (state == TRAN) && (pix == '0);
    assign f2        = pclk | f1_hold;
    assign f1        = ~f2;
    assign rs        = gate & rs_plus;
    assign cp        = gate & cp_phase;

endmodule
